color_mode_seq: RTL

Frame-synchronous sequencer for the colour/mono mixer's `mono` select. It accepts mode-change requests from the OSD/status side over a valid/ready handshake and defers the change to the next vertical-blank edge. It then forces the output to black for a fixed number of frames so the switch never tears mid-frame. It sits between the core's status decoding and the colour mixer, driving the mixer's mode input and a blank-force signal used downstream.

---
 rtl/color_mode_seq_if.sv | 30 +++
 rtl/color_mode_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/color_mode_seq_if.sv
// ---------------------------------------------------------------------------
// color_mode_seq_if
//
// Purpose : mode-change request channel between the OSD/status side
//           (master, the requester) and color_mode_seq (slave).
//
// Signals :
//   req_valid  master -> slave  request valid; held by the master until it
//                               sees req_ready high
//   req_mode   master -> slave  requested mode: 0 colour, 1 green, 2 amber,
//                               3 blue, 4..7 grey
//   req_ready  slave  -> master high when a request can be accepted
// ---------------------------------------------------------------------------
interface color_mode_seq_if;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_mode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        output req_ready
    );
endinterface

// File: rtl/color_mode_seq.sv
// ---------------------------------------------------------------------------
// color_mode_seq
//
// Purpose : frame-synchronous sequencer for the colour/mono mixer's mode
//           select. A mode-change request is accepted over a valid/ready
//           handshake, the actual switch is deferred to the next VBlank
//           rising edge, and the picture is forced black for HOLD_FRAMES
//           further VBlank rising edges so the switch never tears mid-frame.
//
// Parameters:
//   HOLD_FRAMES  number of VBlank rising edges force_blank stays high after
//                a switch (1..15)
//
// Ports:
//   clk_vid      in   video clock, all logic on its rising edge
//   reset_n      in   asynchronous active-low reset
//   ce_pix       in   pixel clock enable; VBlank_in is sampled only when high
//   VBlank_in    in   vertical blank from the video timing chain
//   req          slave modport of color_mode_seq_if (valid/mode/ready)
//   mono_out     out  mode select to the colour mixer (registered)
//   force_blank  out  output must be black (registered)
//   busy         out  sequencer not idle (registered)
//   done         out  one-cycle pulse when a request completes (registered)
// ---------------------------------------------------------------------------
module color_mode_seq #(
    parameter int HOLD_FRAMES = 2
) (
    input  logic              clk_vid,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              VBlank_in,
    color_mode_seq_if.slave   req,
    output logic [2:0]        mono_out,
    output logic              force_blank,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VB = 2'd1,
        S_HOLD    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // The first VBlank edge performs the switch; the counter then covers the
    // remaining HOLD_FRAMES edges, expiring on the edge where it reads zero.
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES - 1);

    state_t     state_q, state_d;
    logic [2:0] mono_q, mono_d;
    logic [2:0] pend_q, pend_d;
    logic [3:0] cnt_q, cnt_d;
    logic       blank_q, blank_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       vb_q;

    logic       vb_rise;
    logic       accept;

    // ------------------------------------------------------------------
    // VBlank edge detection. The previous-level register only advances on
    // pixel-enable cycles, so a level change seen while ce_pix is low is
    // reported on the first following enabled cycle, and a pulse that never
    // overlaps ce_pix is invisible. Resetting it to 1 keeps a VBlank that is
    // already high at reset release from looking like an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            vb_q <= 1'b1;
        end else if (ce_pix) begin
            vb_q <= VBlank_in;
        end
    end

    assign vb_rise = ce_pix & VBlank_in & ~vb_q;

    // Ready is decoded straight from the state register.
    assign req.req_ready = (state_q == S_IDLE);
    assign accept        = req.req_valid & (state_q == S_IDLE);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mono_q  <= 3'd0;
            pend_q  <= 3'd0;
            cnt_q   <= 4'd0;
            blank_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mono_q  <= mono_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mono_d  = mono_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;

        unique case (state_q)
            S_IDLE: begin
                // A VBlank edge in this same cycle is deliberately ignored:
                // the switch waits for a strictly later edge.
                if (accept) begin
                    pend_d = req.req_mode;
                    // Requesting the mode already shown needs no blanking.
                    if (req.req_mode == mono_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_VB;
                    end
                end
            end

            S_WAIT_VB: begin
                if (vb_rise) begin
                    mono_d  = pend_q;
                    blank_d = 1'b1;
                    cnt_d   = HOLD_INIT;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (vb_rise) begin
                    if (cnt_q == 4'd0) begin
                        blank_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // done and busy are registered images of the next state, so they line
    // up exactly with the state register rather than lagging it.
    assign done_d = (state_d == S_DONE);
    assign busy_d = (state_d != S_IDLE);

    assign mono_out    = mono_q;
    assign force_blank = blank_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
